// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, one-outstanding imem fetch, small instruction FIFO toward decode; FETCH_MISALIGN_TRAP_EN enables the misaligned-redirect trap
module fetch_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_en,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready,
    output logic                  misalign_err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, WAIT_DROP} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] req_pc;
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_pc [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count;
    logic                  halt;
    logic                  accept;
    logic                  push;
    logic                  pop;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign halt = misalign_err;
`else
    assign halt = 1'b0;
    assign misalign_err = 1'b0;
`endif

    // A new request may overlap the response of the current one only if that response still leaves room for it
    assign imem_req = !rst && !redirect_en && !halt &&
                      ((state == IDLE && count < CW'(FIFO_DEPTH)) ||
                       (state == WAIT && imem_rvalid && count < CW'(FIFO_DEPTH - 1)));
    assign imem_addr   = pc;
    assign accept      = imem_req && imem_ready;
    assign push        = state == WAIT && imem_rvalid && !redirect_en;
    assign instr_valid = count != '0;
    assign pop         = instr_valid && instr_ready && !redirect_en;
    assign instr       = fifo_data[rd_ptr];
    assign instr_pc    = fifo_pc[rd_ptr];

    // PC, request tracking FSM and instruction FIFO; a redirect overrides everything else
    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
            state  <= IDLE;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_err <= 1'b0;
`endif
        end else if (redirect_en) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            pc <= redirect_pc;
            if (redirect_pc[1:0] != 2'b00) misalign_err <= 1'b1;
`else
            pc <= redirect_pc & ~ADDR_WIDTH'(3);
`endif
            state  <= (state != IDLE && !imem_rvalid) ? WAIT_DROP : IDLE;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                pc     <= pc + ADDR_WIDTH'(4);
                req_pc <= pc;
            end
            if (push) begin
                fifo_data[wr_ptr] <= imem_rdata;
                fifo_pc[wr_ptr]   <= req_pc;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
            state <= accept ? WAIT : (imem_rvalid ? IDLE : state);
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenario tests for fetch_unit against a fixed-latency imem model
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b1;
    logic        misalign_err;

    int          errors = 0;
    int          checks = 0;
    int          lat = 1;
    int          lat_cnt = 0;
    logic [31:0] lat_addr = '0;
    logic [31:0] pq[$];
    logic [31:0] dq[$];

    fetch_unit dut (
        .clk(clk), .rst(rst), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory answers each accepted request exactly lat cycles later
    always @(posedge clk) begin
        if (rst) lat_cnt <= 0;
        else if (imem_req && imem_ready) begin
            lat_cnt  <= lat;
            lat_addr <= imem_addr;
        end else if (lat_cnt != 0) lat_cnt <= lat_cnt - 1;
    end
    assign imem_rvalid = lat_cnt == 1;
    assign imem_rdata  = word_of(lat_addr);

    // Record every instruction handed to decode
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready && !redirect_en) begin
            pq.push_back(instr_pc);
            dq.push_back(instr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1; redirect_en = 1'b0; redirect_pc = '0;
        imem_ready = 1'b1; instr_ready = 1'b1; lat = 1;
        tick();
        pq.delete(); dq.delete();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", misalign_err); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
    endtask

    task automatic test_stream();
        rst = 1'b0;
        #1;
        checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL stream_c0 got=%b/%h exp=1/0", imem_req, imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_c0_valid got=%b exp=0", instr_valid); end
        tick(); #1;
        checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h4}) begin errors++; $display("FAIL stream_c1 got=%b/%h exp=1/4", imem_req, imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_c1_valid got=%b exp=0", instr_valid); end
        tick(); #1;
        checks++; if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h0, word_of(32'h0)}) begin errors++; $display("FAIL stream_c2_head got=%b/%h/%h exp=1/0/%h", instr_valid, instr_pc, instr, word_of(32'h0)); end
        repeat (12) tick();
        checks++; if (pq.size() < 3) begin errors++; $display("FAIL stream_count got=%0d exp>=3", pq.size()); end
        else for (int i = 0; i < 3; i++) begin
            checks++; if ({pq[i], dq[i]} !== {32'(4 * i), word_of(32'(4 * i))}) begin errors++; $display("FAIL stream_pop%0d got=%h/%h exp=%h", i, pq[i], dq[i], 4 * i); end
        end
    endtask

    task automatic test_fifo_stall();
        do_reset();
        rst = 1'b0; instr_ready = 1'b0;
        tick(); tick(); #1;
        checks++; if ({instr_valid, instr_pc} !== {1'b1, 32'h0}) begin errors++; $display("FAIL stall_c2 got=%b/%h exp=1/0", instr_valid, instr_pc); end
        tick(); #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_full_req got=%b exp=0", imem_req); end
        tick(); tick(); #1;
        checks++; if ({imem_req, instr_valid, instr_pc, instr} !== {2'b01, 32'h0, word_of(32'h0)}) begin errors++; $display("FAIL stall_c5 got=%b/%b/%h/%h exp=0/1/0", imem_req, instr_valid, instr_pc, instr); end
        checks++; if (pq.size() !== 0) begin errors++; $display("FAIL stall_nopop got=%0d exp=0", pq.size()); end
        tick();
        instr_ready = 1'b1;
        repeat (10) tick();
        checks++; if (pq.size() < 3) begin errors++; $display("FAIL stall_count got=%0d exp>=3", pq.size()); end
        else for (int i = 0; i < 3; i++) begin
            checks++; if ({pq[i], dq[i]} !== {32'(4 * i), word_of(32'(4 * i))}) begin errors++; $display("FAIL stall_pop%0d got=%h/%h exp=%h", i, pq[i], dq[i], 4 * i); end
        end
    endtask

    task automatic test_redirect_drop();
        do_reset();
        lat = 2; rst = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h10;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL drop_redir_req got=%b exp=0", imem_req); end
        tick();
        redirect_en = 1'b0;
        #1;
        checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h10}) begin errors++; $display("FAIL drop_req10 got=%b/%h exp=1/10", imem_req, imem_addr); end
        tick();
        redirect_en = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_en = 1'b0;
        #1;
        checks++; if ({imem_req, instr_valid} !== 2'b00) begin errors++; $display("FAIL drop_draining got=%b/%b exp=0/0", imem_req, instr_valid); end
        tick(); #1;
        checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin errors++; $display("FAIL drop_req100 got=%b/%h exp=1/100", imem_req, imem_addr); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL drop_stale%0d got=%b exp=0", k, instr_valid); end
            tick(); #1;
        end
        checks++; if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h100, word_of(32'h100)}) begin errors++; $display("FAIL drop_head got=%b/%h/%h exp=1/100", instr_valid, instr_pc, instr); end
    endtask

    task automatic test_redirect_rvalid();
        do_reset();
        rst = 1'b0;
        tick(); tick();
        redirect_en = 1'b1; redirect_pc = 32'h100;
        #1;
        checks++; if ({instr_valid, imem_rvalid, imem_req} !== 3'b110) begin errors++; $display("FAIL rv_pre got=%b/%b/%b exp=1/1/0", instr_valid, imem_rvalid, imem_req); end
        tick();
        redirect_en = 1'b0;
        #1;
        checks++; if ({instr_valid, imem_req, imem_addr} !== {2'b01, 32'h100}) begin errors++; $display("FAIL rv_flush got=%b/%b/%h exp=0/1/100", instr_valid, imem_req, imem_addr); end
        checks++; if (pq.size() !== 0) begin errors++; $display("FAIL rv_nopop got=%0d exp=0", pq.size()); end
        tick(); tick(); #1;
        checks++; if ({instr_valid, instr_pc} !== {1'b1, 32'h100}) begin errors++; $display("FAIL rv_head got=%b/%h exp=1/100", instr_valid, instr_pc); end
    endtask

    task automatic test_imem_stall();
        do_reset();
        imem_ready = 1'b0; rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL istall%0d got=%b/%h exp=1/0", k, imem_req, imem_addr); end
            tick();
        end
        imem_ready = 1'b1;
        #1;
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL istall_release got=%h exp=0", imem_addr); end
        tick(); #1;
        checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h4}) begin errors++; $display("FAIL istall_next got=%b/%h exp=1/4", imem_req, imem_addr); end
    endtask

    task automatic test_misalign();
        do_reset();
        rst = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect_en = 1'b0;
        #1;
`ifdef FETCH_MISALIGN_TRAP_EN
        checks++; if ({misalign_err, imem_req} !== 2'b10) begin errors++; $display("FAIL mis_set got=%b/%b exp=1/0", misalign_err, imem_req); end
        repeat (3) tick();
        #1;
        checks++; if ({misalign_err, imem_req, instr_valid} !== 3'b100) begin errors++; $display("FAIL mis_hold got=%b/%b/%b exp=1/0/0", misalign_err, imem_req, instr_valid); end
        do_reset();
        rst = 1'b0;
        #1;
        checks++; if ({misalign_err, imem_req} !== 2'b01) begin errors++; $display("FAIL mis_clear got=%b/%b exp=0/1", misalign_err, imem_req); end
`else
        checks++; if ({misalign_err, imem_req, imem_addr} !== {2'b01, 32'h100}) begin errors++; $display("FAIL mis_mask got=%b/%b/%h exp=0/1/100", misalign_err, imem_req, imem_addr); end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fifo_stall();
        test_redirect_drop();
        test_redirect_rvalid();
        test_imem_stall();
        test_misalign();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
